// File: rtl/hbridge_pkg.sv
// rtl/hbridge_pkg.sv - shared state encoding and sizing helper for the H-bridge direction guard
package hbridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Width of a down-counter that must hold DEAD_CYCLES-1; never below one bit.
    function automatic int cnt_width(input int dead_cycles);
        return (dead_cycles < 1) ? 1 : $clog2(dead_cycles + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hbridge_dir_guard.sv
// rtl/hbridge_dir_guard.sv - dead-time and fault guard between pwm_gen_0 and the H-bridge inputs
module hbridge_dir_guard
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES = 50,
    parameter int REV_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 pwm_in,
    input  logic                 dir_in,
    input  logic                 fault_in,
    input  logic                 fault_clr,
    output logic                 hb_in1,
    output logic                 hb_in2,
    output logic                 busy,
    output logic                 fault_latched,
    output logic [REV_CNT_W-1:0] rev_count
);

    localparam int               CNT_W    = cnt_width(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_dir;
    logic             w_dir_next;
    logic             w_rev_inc;
    logic             r_hb1;
    logic             r_hb2;
    logic             r_busy;
    logic             r_fault;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        w_rev_inc  = 1'b0;
        if (fault_in) begin
            w_next     = FAULT;
            w_cnt_next = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (enable) begin
                        w_next     = DEAD;
                        w_cnt_next = CNT_LOAD;
                        w_dir_next = dir_in;
                    end
                end
                DEAD: begin
                    if (!enable) begin
                        w_next     = IDLE;
                        w_cnt_next = '0;
                    end else if (dir_in != r_dir) begin
                        w_cnt_next = CNT_LOAD;
                        w_dir_next = dir_in;
                    end else if (r_cnt == '0) begin
                        w_next = RUN;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        w_next = IDLE;
                    end else if (dir_in != r_dir) begin
                        w_next     = DEAD;
                        w_cnt_next = CNT_LOAD;
                        w_dir_next = dir_in;
                        w_rev_inc  = 1'b1;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so RUN echoes pwm_in exactly one cycle late
    // and the bridge drops on the same edge that leaves RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_hb1   <= 1'b0;
            r_hb2   <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_hb1   <= (w_next == RUN) && pwm_in && r_dir;
            r_hb2   <= (w_next == RUN) && pwm_in && !r_dir;
            r_busy  <= (w_next == DEAD);
            r_fault <= (w_next == FAULT);
        end
    end

    sat_counter #(
        .W (REV_CNT_W)
    ) u_rev_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_inc   (w_rev_inc),
        .o_count (rev_count)
    );

    assign hb_in1        = r_hb1;
    assign hb_in2        = r_hb2;
    assign busy          = r_busy;
    assign fault_latched = r_fault;

endmodule

// File: tb/tb_hbridge_dir_guard.sv
// tb/tb_hbridge_dir_guard.sv - directed and random checks of hbridge_dir_guard
module tb_hbridge_dir_guard;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       pwm_in;
    logic       dir_in;
    logic       fault_in;
    logic       fault_clr;
    logic       hb_in1;
    logic       hb_in2;
    logic       busy;
    logic       fault_latched;
    logic [3:0] rev_count;

    int total;
    int bad;

    hbridge_dir_guard #(
        .DEAD_CYCLES (4),
        .REV_CNT_W   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .dir_in        (dir_in),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .hb_in1        (hb_in1),
        .hb_in2        (hb_in2),
        .busy          (busy),
        .fault_latched (fault_latched),
        .rev_count     (rev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        dir_in    = 1'b0;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        repeat (2) step();
        total++;
        if ({hb_in1, hb_in2, busy, fault_latched} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=0000", {hb_in1, hb_in2, busy, fault_latched});
        end
        total++;
        if (rev_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_rev got=%0d exp=0", rev_count);
        end
        reset_n = 1'b1;
        step();
        total++;
        if ({hb_in1, hb_in2, busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got=%b exp=000", {hb_in1, hb_in2, busy});
        end
    endtask

    task automatic test_start();
        enable = 1'b1;
        dir_in = 1'b1;
        pwm_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({busy, hb_in1, hb_in2} !== 3'b100) begin
                bad++;
                $display("FAIL start_dead[%0d] got=%b exp=100", i, {busy, hb_in1, hb_in2});
            end
        end
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b010) begin
            bad++;
            $display("FAIL start_run got=%b exp=010", {busy, hb_in1, hb_in2});
        end
        pwm_in = 1'b0;
        step();
        total++;
        if (hb_in1 !== 1'b0) begin
            bad++;
            $display("FAIL echo_low got=%b exp=0", hb_in1);
        end
        pwm_in = 1'b1;
        step();
        total++;
        if (hb_in1 !== 1'b1) begin
            bad++;
            $display("FAIL echo_high got=%b exp=1", hb_in1);
        end
    endtask

    task automatic test_reversal();
        dir_in = 1'b0;
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b100 || rev_count !== 4'd1) begin
            bad++;
            $display("FAIL rev_enter got=%b rev=%0d exp=100 rev=1", {busy, hb_in1, hb_in2}, rev_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({busy, hb_in1, hb_in2} !== 3'b100) begin
                bad++;
                $display("FAIL rev_dead[%0d] got=%b exp=100", i, {busy, hb_in1, hb_in2});
            end
        end
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b001) begin
            bad++;
            $display("FAIL rev_run got=%b exp=001", {busy, hb_in1, hb_in2});
        end
        pwm_in = 1'b0;
        step();
        total++;
        if (hb_in2 !== 1'b0) begin
            bad++;
            $display("FAIL rev_echo_low got=%b exp=0", hb_in2);
        end
        pwm_in = 1'b1;
        step();
        total++;
        if (hb_in2 !== 1'b1 || rev_count !== 4'd1) begin
            bad++;
            $display("FAIL rev_echo_high got=%b rev=%0d exp=1 rev=1", hb_in2, rev_count);
        end
    endtask

    task automatic test_dead_restart();
        dir_in = 1'b1;
        step();
        step();
        dir_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({busy, hb_in1, hb_in2} !== 3'b100) begin
                bad++;
                $display("FAIL restart_dead[%0d] got=%b exp=100", i, {busy, hb_in1, hb_in2});
            end
        end
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b001) begin
            bad++;
            $display("FAIL restart_run got=%b exp=001", {busy, hb_in1, hb_in2});
        end
        total++;
        if (rev_count !== 4'd2) begin
            bad++;
            $display("FAIL restart_rev got=%0d exp=2", rev_count);
        end
    endtask

    task automatic test_fault();
        fault_in = 1'b1;
        step();
        total++;
        if ({fault_latched, busy, hb_in1, hb_in2} !== 4'b1000) begin
            bad++;
            $display("FAIL fault_enter got=%b exp=1000", {fault_latched, busy, hb_in1, hb_in2});
        end
        fault_in = 1'b0;
        step();
        total++;
        if (fault_latched !== 1'b1) begin
            bad++;
            $display("FAIL fault_hold got=%b exp=1", fault_latched);
        end
        fault_in  = 1'b1;
        fault_clr = 1'b1;
        step();
        total++;
        if (fault_latched !== 1'b1) begin
            bad++;
            $display("FAIL fault_clr_ignored got=%b exp=1", fault_latched);
        end
        fault_in = 1'b0;
        step();
        total++;
        if ({fault_latched, busy, hb_in1, hb_in2} !== 4'b0000) begin
            bad++;
            $display("FAIL fault_clr got=%b exp=0000", {fault_latched, busy, hb_in1, hb_in2});
        end
        fault_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({busy, hb_in1, hb_in2} !== 3'b100) begin
                bad++;
                $display("FAIL fault_dead[%0d] got=%b exp=100", i, {busy, hb_in1, hb_in2});
            end
        end
        step();
        total++;
        if ({fault_latched, busy, hb_in1, hb_in2} !== 4'b0001) begin
            bad++;
            $display("FAIL fault_run got=%b exp=0001", {fault_latched, busy, hb_in1, hb_in2});
        end
    endtask

    task automatic test_saturate();
        int exp_rev;
        exp_rev = 2;
        for (int i = 0; i < 20; i++) begin
            dir_in = ~dir_in;
            step();
            exp_rev = (exp_rev == 15) ? 15 : exp_rev + 1;
            total++;
            if (rev_count !== 4'(exp_rev)) begin
                bad++;
                $display("FAIL sat_rev[%0d] got=%0d exp=%0d", i, rev_count, exp_rev);
            end
            repeat (4) step();
        end
        total++;
        if (rev_count !== 4'd15) begin
            bad++;
            $display("FAIL sat_final got=%0d exp=15", rev_count);
        end
    endtask

    task automatic test_async_reset();
        dir_in = ~dir_in;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, hb_in1, hb_in2, fault_latched} !== 4'b0000 || rev_count !== 4'd0) begin
            bad++;
            $display("FAIL areset_dead got=%b rev=%0d exp=0000 rev=0", {busy, hb_in1, hb_in2, fault_latched}, rev_count);
        end
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b000) begin
            bad++;
            $display("FAIL areset_idle got=%b exp=000", {busy, hb_in1, hb_in2});
        end
        dir_in = 1'b1;
        pwm_in = 1'b1;
        enable = 1'b1;
        repeat (4) step();
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b010) begin
            bad++;
            $display("FAIL areset_rerun got=%b exp=010", {busy, hb_in1, hb_in2});
        end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, hb_in1, hb_in2, fault_latched} !== 4'b0000) begin
            bad++;
            $display("FAIL areset_run got=%b exp=0000", {busy, hb_in1, hb_in2, fault_latched});
        end
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if ({busy, hb_in1, hb_in2} !== 3'b000) begin
            bad++;
            $display("FAIL areset_run_idle got=%b exp=000", {busy, hb_in1, hb_in2});
        end
    endtask

    task automatic test_random();
        logic exp_fault;
        exp_fault = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            pwm_in    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dir_in = ~dir_in;
            enable    = ($urandom_range(0, 31) != 0);
            fault_in  = ($urandom_range(0, 63) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            exp_fault = fault_in ? 1'b1 : (exp_fault && !fault_clr);
            step();
            total++;
            if ((hb_in1 & hb_in2) !== 1'b0) begin
                bad++;
                $display("FAIL shoot_through[%0d] got=%b%b exp=not 11", i, hb_in1, hb_in2);
            end
            total++;
            if (fault_latched !== exp_fault) begin
                bad++;
                $display("FAIL rand_fault[%0d] got=%b exp=%b", i, fault_latched, exp_fault);
            end
        end
        fault_in  = 1'b0;
        fault_clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_start();
        test_reversal();
        test_dead_restart();
        test_fault();
        test_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
